// File: rtl/pool_window_ctrl_if.sv
// Bundle between the 2x2 window sequencer, its input SRAM, the pooling unit and the output buffer.
// master = sequencer side, slave = memory / pooling / output-buffer side.
interface pool_window_ctrl_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              pool_en;
    logic [DATA_W-1:0] pool_data;
    logic [DATA_W-1:0] pool_result;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  start,
        output busy,
        output done,
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output pool_en,
        output pool_data,
        input  pool_result,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  pool_en,
        input  pool_data,
        output pool_result,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/pool_window_ctrl.sv
// Raster-order 2x2 window sequencer feeding the max-pooling unit, 6 cycles per window.
// Optional macro POOL_CTRL_RELU_EN zeroes negative words on their way into the pooling unit.
module pool_window_ctrl #(
    parameter int unsigned IMG_W   = 8,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RD_BASE = 0,
    parameter int unsigned WR_BASE = 0
) (
    input  logic                clk,
    input  logic                rst,
    pool_window_ctrl_if.master  bus
);
    localparam int unsigned HALF  = IMG_W / 2;
    localparam int unsigned IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned PH_W  = 3;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(5);
    localparam logic [PH_W-1:0]  PH_RDEND = PH_W'(4);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [IDX_W-1:0]  row_q, row_d;
    logic [IDX_W-1:0]  col_q, col_d;

    logic              rd_en_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [ADDR_W-1:0] rd_off;

    logic              in_run;
    logic              load_phase;
    logic              wr_phase;
    logic [DATA_W-1:0] feed_data;

    // State, window indices and the registered strobe/address outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            phase_q         <= '0;
            row_q           <= '0;
            col_q           <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.pool_en     <= 1'b0;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_rd_addr <= '0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            row_q           <= row_d;
            col_q           <= col_d;
            bus.busy        <= (state_d == RUN);
            bus.done        <= (state_d == DONE);
            bus.pool_en     <= (state_d == RUN);
            bus.mem_rd_en   <= rd_en_d;
            bus.mem_rd_addr <= rd_addr_d;
        end
    end

    // Next state plus the read strobe/address decoded from it so they land in the same cycle
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        row_d     = row_q;
        col_d     = col_q;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        rd_off    = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    phase_d = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (row_q == IDX_LAST && col_q == IDX_LAST) begin
                        state_d = DONE;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == IDX_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (phase_d)
            PH_W'(1): rd_off = ADDR_W'(1);
            PH_W'(2): rd_off = ADDR_W'(IMG_W);
            PH_W'(3): rd_off = ADDR_W'(IMG_W + 1);
            default:  rd_off = '0;
        endcase

        if (state_d == RUN && phase_d < PH_RDEND) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ADDR_W'(RD_BASE)
                      + ADDR_W'(row_d) * ADDR_W'(2 * IMG_W)
                      + (ADDR_W'(col_d) << 1)
                      + rd_off;
        end
    end

`ifdef POOL_CTRL_RELU_EN
    assign feed_data = bus.mem_rd_data[DATA_W-1] ? '0 : bus.mem_rd_data;
`else
    assign feed_data = bus.mem_rd_data;
`endif

    // SRAM data arrives one cycle after each read, i.e. in phases 1..4
    assign in_run     = (state_q == RUN);
    assign load_phase = in_run && (phase_q != '0) && (phase_q <= PH_RDEND);
    assign wr_phase   = in_run && (phase_q == PH_LAST);

    assign bus.pool_data = load_phase ? feed_data : '0;
    assign bus.wr_en     = wr_phase;
    assign bus.wr_addr   = wr_phase ? (ADDR_W'(WR_BASE)
                                       + ADDR_W'(row_q) * ADDR_W'(HALF)
                                       + ADDR_W'(col_q))
                                    : '0;
    assign bus.wr_data   = wr_phase ? bus.pool_result : '0;
endmodule

// File: tb/tb_pool_window_ctrl.sv
// Bench for pool_window_ctrl: IMG_W=4 and IMG_W=2 instances with a behavioural SRAM and pooling unit.
// Expected traffic comes from the raster window rules; honours POOL_CTRL_RELU_EN when defined.
module tb_pool_window_ctrl;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned WB = 32;
    localparam int          NA = 4;   // windows in the 4x4 map

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pool_window_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    pool_window_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    pool_window_ctrl #(.IMG_W(4), .ADDR_W(AW), .DATA_W(DW), .RD_BASE(0), .WR_BASE(WB))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    pool_window_ctrl #(.IMG_W(2), .ADDR_W(AW), .DATA_W(DW), .RD_BASE(0), .WR_BASE(WB))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    logic [DW-1:0] mem [0:4095];
    int            pcnt_a = 0, pcnt_b = 0;
    logic [DW-1:0] pacc_a = '0, pacc_b = '0;
    int            n_pass = 0, n_total = 0;
    logic [DW-1:0] got_wr [NA];

    // Synchronous-read SRAM, one port per instance
    always @(posedge clk) begin
        if (bus_a.mem_rd_en) bus_a.mem_rd_data <= mem[bus_a.mem_rd_addr];
        if (bus_b.mem_rd_en) bus_b.mem_rd_data <= mem[bus_b.mem_rd_addr];
    end

    // Pooling unit: clear at count 0, max-load at 1..4, result visible at 5
    always @(posedge clk) begin
        if (!bus_a.pool_en) pcnt_a <= 0;
        else begin
            pcnt_a <= (pcnt_a == 5) ? 0 : pcnt_a + 1;
            if (pcnt_a == 0) pacc_a <= '0;
            else if (pcnt_a <= 4 && bus_a.pool_data > pacc_a) pacc_a <= bus_a.pool_data;
        end
        if (!bus_b.pool_en) pcnt_b <= 0;
        else begin
            pcnt_b <= (pcnt_b == 5) ? 0 : pcnt_b + 1;
            if (pcnt_b == 0) pacc_b <= '0;
            else if (pcnt_b <= 4 && bus_b.pool_data > pacc_b) pacc_b <= bus_b.pool_data;
        end
    end
    assign bus_a.pool_result = pacc_a;
    assign bus_b.pool_result = pacc_b;

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef POOL_CTRL_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Address of the q-th word (0..3) of window w in a map of width img_w
    function automatic int rd_addr_of(input int img_w, input int w, input int q);
        int r, c, base;
        r    = w / (img_w / 2);
        c    = w % (img_w / 2);
        base = 2 * r * img_w + 2 * c;
        case (q)
            0: return base;
            1: return base + 1;
            2: return base + img_w;
            default: return base + img_w + 1;
        endcase
    endfunction

    function automatic logic [DW-1:0] win_max(input int img_w, input int w);
        logic [DW-1:0] m, v;
        m = '0;
        for (int q = 0; q < 4; q++) begin
            v = relu(mem[rd_addr_of(img_w, w, q)]);
            if (v > m) m = v;
        end
        return m;
    endfunction

    // Runs one frame on the 4x4 instance, checking every cycle 1..6N+2 against the window rules
    task automatic run_frame(input bit hold);
        int w, p;
        bit in_run;
        logic [4:0]    exp_ctrl, got_ctrl;
        logic [DW-1:0] exp_d;
        bus_a.start = 1'b1;
        @(negedge clk);
        if (!hold) bus_a.start = 1'b0;
        for (int k = 1; k <= 6 * NA + 2; k++) begin
            w = (k - 1) / 6;
            p = (k - 1) % 6;
            in_run = (k <= 6 * NA);
            exp_ctrl = {in_run, (k == 6 * NA + 1), in_run, in_run && p < 4, in_run && p == 5};
            got_ctrl = {bus_a.busy, bus_a.done, bus_a.pool_en, bus_a.mem_rd_en, bus_a.wr_en};
            n_total++;
            if (got_ctrl !== exp_ctrl)
                $display("FAIL ctrl cycle %0d: busy/done/pool_en/rd_en/wr_en got %b expected %b", k, got_ctrl, exp_ctrl);
            else n_pass++;
            if (in_run && p < 4) begin
                n_total++;
                if (bus_a.mem_rd_addr !== AW'(rd_addr_of(4, w, p)))
                    $display("FAIL rd_addr cycle %0d: got %0d expected %0d", k, bus_a.mem_rd_addr, rd_addr_of(4, w, p));
                else n_pass++;
            end
            if (in_run && p >= 1 && p <= 4) begin
                exp_d = relu(mem[rd_addr_of(4, w, p - 1)]);
                n_total++;
                if (bus_a.pool_data !== exp_d)
                    $display("FAIL pool_data cycle %0d: got %h expected %h", k, bus_a.pool_data, exp_d);
                else n_pass++;
            end
            if (in_run && p == 5) begin
                exp_d = win_max(4, w);
                got_wr[w] = bus_a.wr_data;
                n_total++;
                if (bus_a.wr_addr !== AW'(WB + w) || bus_a.wr_data !== exp_d)
                    $display("FAIL write cycle %0d: got (%0d,%h) expected (%0d,%h)", k, bus_a.wr_addr, bus_a.wr_data, WB + w, exp_d);
                else n_pass++;
            end
            if (k < 6 * NA + 2) @(negedge clk);
        end
    endtask

    task automatic fill_identity();
        for (int i = 0; i < 64; i++) mem[i] = DW'(i);
    endtask

    task automatic check_all_zero(input string name);
        logic [2*(5+AW+AW+DW+DW)-1:0] got;
        got = {bus_a.busy, bus_a.done, bus_a.pool_en, bus_a.mem_rd_en, bus_a.wr_en,
               bus_a.mem_rd_addr, bus_a.wr_addr, bus_a.wr_data, bus_a.pool_data,
               bus_b.busy, bus_b.done, bus_b.pool_en, bus_b.mem_rd_en, bus_b.wr_en,
               bus_b.mem_rd_addr, bus_b.wr_addr, bus_b.wr_data, bus_b.pool_data};
        n_total++;
        if (got !== '0) $display("FAIL %s: outputs got %h expected all zero", name, got);
        else n_pass++;
    endtask

    task automatic test_reset();
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        fill_identity();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_basic_frame();
        logic [DW-1:0] exp_w [NA];
        exp_w = '{DW'(5), DW'(7), DW'(13), DW'(15)};
        fill_identity();
        run_frame(1'b0);
        for (int i = 0; i < NA; i++) begin
            n_total++;
            if (got_wr[i] !== exp_w[i]) $display("FAIL basic_w%0d: got %0d expected %0d", i, got_wr[i], exp_w[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        fill_identity();
        run_frame(1'b0);
        run_frame(1'b0);
        n_total++;
        if (got_wr[0] !== DW'(5)) $display("FAIL b2b_first: got %0d expected 5", got_wr[0]);
        else n_pass++;
    endtask

    task automatic test_start_held();
        fill_identity();
        run_frame(1'b1);
        run_frame(1'b0);
        @(negedge clk);
        n_total++;
        if (bus_a.busy !== 1'b0) $display("FAIL held_idle: busy got %b expected 0", bus_a.busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int wr_seen;
        fill_identity();
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        wr_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus_a.wr_en || bus_a.busy) wr_seen++;
        end
        n_total++;
        if (wr_seen != 0) $display("FAIL reset_abandon: active cycles got %0d expected 0", wr_seen);
        else n_pass++;
        run_frame(1'b0);
        n_total++;
        if (got_wr[0] !== DW'(5) || got_wr[3] !== DW'(15))
            $display("FAIL reset_refresh: got %0d,%0d expected 5,15", got_wr[0], got_wr[3]);
        else n_pass++;
    endtask

    task automatic test_relu_boundary();
        logic [DW-1:0] exp0;
        fill_identity();
        for (int i = 0; i < 6; i++) mem[i] = 32'hFFFF_FFF0;
`ifdef POOL_CTRL_RELU_EN
        exp0 = '0;
`else
        exp0 = 32'hFFFF_FFF0;
`endif
        run_frame(1'b0);
        n_total++;
        if (got_wr[0] !== exp0) $display("FAIL relu_w0: got %h expected %h", got_wr[0], exp0);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
            run_frame(1'b0);
        end
    endtask

    // Single-window map on the IMG_W=2 instance
    task automatic test_min_image();
        logic [4:0]    exp_ctrl, got_ctrl;
        logic [DW-1:0] exp_d;
        for (int it = 0; it < 2; it++) begin
            for (int i = 0; i < 4; i++) mem[i] = (it == 0) ? DW'(i) : DW'($urandom);
            exp_d = win_max(2, 0);
            if (it == 0) begin
                n_total++;
                if (exp_d !== DW'(3)) $display("FAIL min_model: got %0d expected 3", exp_d);
                else n_pass++;
            end
            bus_b.start = 1'b1;
            @(negedge clk);
            bus_b.start = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                exp_ctrl = {k <= 6, k == 7, k <= 6, k <= 4, k == 6};
                got_ctrl = {bus_b.busy, bus_b.done, bus_b.pool_en, bus_b.mem_rd_en, bus_b.wr_en};
                n_total++;
                if (got_ctrl !== exp_ctrl)
                    $display("FAIL min_ctrl cycle %0d: got %b expected %b", k, got_ctrl, exp_ctrl);
                else n_pass++;
                if (k <= 4) begin
                    n_total++;
                    if (bus_b.mem_rd_addr !== AW'(k - 1))
                        $display("FAIL min_rd_addr cycle %0d: got %0d expected %0d", k, bus_b.mem_rd_addr, k - 1);
                    else n_pass++;
                end
                if (k == 6) begin
                    n_total++;
                    if (bus_b.wr_addr !== AW'(WB) || bus_b.wr_data !== exp_d)
                        $display("FAIL min_write: got (%0d,%h) expected (%0d,%h)", bus_b.wr_addr, bus_b.wr_data, WB, exp_d);
                    else n_pass++;
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_start_held();
        test_reset_mid();
        test_relu_boundary();
        test_random();
        test_min_image();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pool_window_ctrl.md
# pool_window_ctrl

Window sequencer for the 2x2 max-pooling stage. It walks a square feature map held in a synchronous-read SRAM in raster order. For each 2x2 window it feeds four words into the pooling unit under a continuous enable, and writes the pooled result to an output buffer. It sits directly upstream of the pooling unit and owns its `en`/`Data_in` inputs and its `Data_out` result.

## Interface
- `IMG_W`, 8: feature-map width = height, in words; even, >= 2
- `ADDR_W`, 12: address width for both memories
- `DATA_W`, 32: word width; equals `INTERNAL_BITS`
- `RD_BASE`, 0: first address of the input map
- `WR_BASE`, 0: first address of the pooled output map

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  start-frame pulse; sampled only in IDLE
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse after the last write
- `mem_rd_en`  out  1  input SRAM read strobe
- `mem_rd_addr`  out  ADDR_W  input SRAM address
- `mem_rd_data`  in  DATA_W  input SRAM data, valid the cycle after `mem_rd_en`
- `pool_en`  out  1  to pooling `en`
- `pool_data`  out  DATA_W  to pooling `Data_in`
- `pool_result`  in  DATA_W  from pooling `Data_out`
- `wr_en`  out  1  output buffer write strobe
- `wr_addr`  out  ADDR_W  output buffer address
- `wr_data`  out  DATA_W  output buffer data

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DONE after phase 5 of the last window.
  - DONE -> IDLE unconditionally, after one cycle.
- In RUN, a 3-bit phase counter cycles 0..5, one window per 6 cycles.
- Window indices: row r and column c, each in 0..IMG_W/2-1, column fastest. N = (IMG_W/2)^2 windows.
- Phases 0..3: `mem_rd_en`=1. `mem_rd_addr` = RD_BASE + 2r·IMG_W + 2c, then +1, then +IMG_W, then +IMG_W+1.
- Phases 1..4: `pool_data` = `mem_rd_data`, combinational pass-through (subject to Configuration).
- Phase 5: `wr_en`=1, `wr_addr` = WR_BASE + r·(IMG_W/2) + c, `wr_data` = `pool_result`.
- Other phases: `wr_en`=0, `pool_data`=0.
- `pool_en`:
  - High for every RUN cycle, continuous across windows.
  - Its phase counter matches the pooling unit's internal counter exactly: pooling clears at its count 0, loads at 1..4, presents at 5.
  - Low in IDLE and DONE; this low cycle re-zeroes the pooling counter between frames.
- Address arithmetic is modulo 2^ADDR_W; wrap is not flagged.
- `start` in RUN or DONE is ignored, not queued.
- Reset mid-frame:
  - Return to IDLE and drop all strobes.
  - Pooling sees `pool_en`=0 and resynchronises. The partial frame is abandoned.

## Timing
- Reset values:
  - `busy`, `done`, `mem_rd_en`, `pool_en`, `wr_en` = 0.
  - `mem_rd_addr`, `wr_addr`, `wr_data`, `pool_data` = 0.
  - State IDLE, phase 0, r = c = 0.
- Cycle counting: `start` is sampled at edge E0; cycle 1 is the cycle after E0.
  - Cycle 1 is RUN phase 0 of window 0.
  - Window k occupies cycles 6k+1..6k+6.
  - Write of window k occurs in cycle 6k+6.
- `busy` is high for cycles 1..6N. `done` is high in cycle 6N+1.
- Earliest next `start` is accepted in cycle 6N+2.
- SRAM read latency is exactly 1 cycle; `mem_rd_data` is not registered internally.
- `wr_*` is combinational from the phase, `pool_result` and the registered indices; it is valid during phase 5 only.

## Configuration
- Macro `POOL_CTRL_RELU_EN`.
- Defined: in phases 1..4, `pool_data` = 0 when `mem_rd_data[DATA_W-1]` = 1, else `mem_rd_data`. This gives fused ReLU ahead of the unsigned max compare.
- Undefined: `pool_data` = `mem_rd_data` unmodified.
- Timing is identical in both builds.

## Test plan
Common setup: IMG_W=4, RD_BASE=0, WR_BASE=32, `mem[i]` = i, with the real pooling unit attached.
- Basic frame: pulse `start` -> writes (32,5), (33,7), (34,13), (35,15) in cycles 6, 12, 18, 24. `done` in cycle 25. `busy` high in cycles 1..24.
- Back-to-back frames: `start` again in cycle 26 -> identical write sequence. First window result is 5, showing the pooling counter resynchronised.
- `start` held high through the frame -> one frame only until DONE->IDLE. Then a second frame starts because `start` is still high in IDLE.
- Reset at cycle 10 -> all outputs 0 immediately, no further `wr_en`. A fresh `start` then reproduces the basic-frame result.
- With `POOL_CTRL_RELU_EN` defined, `mem[0..5]` = 0xFFFF_FFF0 -> window 0 writes 0. Without it -> window 0 writes 0xFFFF_FFF0.
- IMG_W=2 -> single window reading addresses 0, 1, 2, 3, write (32,3) in cycle 6, `done` in cycle 7.
